vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates the 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock. It counts pixels per line and lines per frame, and produces hsync, vsync, data-enable, the active pixel coordinate and frame/line strobes. It sits directly downstream of the pixel clock divider and feeds the pixel generator and the VGA output pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- CNT_W, 10, counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- clk_pix  input  1  pixel clock, 25 MHz, sole clock
- reset  input  1  synchronous, active-high reset
- en  input  1  advance enable; low freezes counters and outputs
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- de  output  1  high during the active region
- x  output  CNT_W  active pixel column, 0..H_ACTIVE-1; 0 outside the active region
- y  output  CNT_W  active line, 0..V_ACTIVE-1; 0 outside the active region
- line_start  output  1  one-cycle pulse on pixel h=0 of every line
- frame_start  output  1  one-cycle pulse on pixel (h=0, v=0)

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525).
- Internal counters: h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1, both unsigned CNT_W.
- When en=1 on a clk_pix edge:
  - h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - When v_cnt is at V_TOTAL-1 on the h wrap, v_cnt also wraps to 0.
- When en=0, counters and all outputs hold.
- Region decode:
  - active: h < H_ACTIVE and v < V_ACTIVE
  - hsync asserted: H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC (656..751)
  - vsync asserted: V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC (490..491)
- Asserted sync level = SYNC_POL; inactive level = ~SYNC_POL.
- vsync changes on the same pixel as the h wrap (h=0 of line 490 and line 492). It is not offset to the hsync edge.
- There is no state machine beyond the two counters. Region flags are pure comparisons on the counters.

## Timing
- Reset (synchronous, reset high at an edge):
  - h_cnt=0, v_cnt=0.
  - hsync=vsync=~SYNC_POL, de=0, x=0, y=0, line_start=0, frame_start=0.
- All outputs are registered decodes of the pre-increment counter value: 1-cycle latency from counter to outputs.
- First enabled edge after reset deasserts:
  - outputs show the decode of (0,0): de=1, x=0, y=0, line_start=1, frame_start=1
  - counters move to (1,0).
- Reset asserted mid-frame overrides en and takes effect at the next edge; the raster restarts at (0,0) with no partial-frame artifacts.
- Line period 800 enabled cycles; frame period 420000 enabled cycles.
- frame_start implies line_start.
- en may toggle on any cycle. Output sequences are identical to an always-enabled run with the disabled cycles removed.

## Structure
- Package vga_timing_pkg holds:
  - the default 640x480 timing constants (H_*, V_*)
  - derived H_TOTAL and V_TOTAL
  - sync/porch boundary constants (H_SYNC_START, H_SYNC_END, V_SYNC_START, V_SYNC_END)
  - CNT_W
- One natural sub-module, axis_timing_counter, instantiated twice (horizontal and vertical):
  - parameterised wrap counter with inc and wrap outputs
  - active and sync region flags

## Test plan
- Reset released, en=1 for 800 cycles:
  - de high exactly cycles 0..639, x = 0..639
  - hsync low exactly cycles 656..751
  - line_start only at cycle 0 and cycle 800
- Full frame, en=1 for 420000 cycles:
  - 480 lines with de; vsync low exactly for lines 490..491 (1600 cycles)
  - frame_start only at cycles 0 and 420000
- en driven with a pseudo-random 50 % pattern for two frames: compacted output stream matches the en=1 golden model bit-exactly.
- Reset pulsed for 1 cycle at line 300, pixel 400:
  - next edge gives reset outputs
  - following enabled edge gives frame_start=1, x=0, y=0
- SYNC_POL=1 build: hsync high at h=656..751 and low elsewhere; vsync high on lines 490..491.
- Boundary checks:
  - at h=799, v=524 the next enabled edge wraps the counters to (0,0)
  - x and y never exceed 639 and 479
  - x=y=0 whenever de=0

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing constants and small shared helpers.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;

    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Sync windows are [START, END): END is the first non-sync count.
    localparam int H_SYNC_START = H_ACTIVE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int CNT_W    = 10;
    localparam bit SYNC_POL = 1'b0;

    function automatic logic sync_level(input logic asserted,
                                        input logic pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/axis_timing_counter.sv
// One raster axis: wrapping position counter plus active/sync region flags.
module axis_timing_counter
    import vga_timing_pkg::*;
#(
    parameter int W          = CNT_W,
    parameter int TOTAL      = H_TOTAL,
    parameter int ACTIVE     = H_ACTIVE,
    parameter int SYNC_START = H_SYNC_START,
    parameter int SYNC_END   = H_SYNC_END
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o,
    output logic         active_o,
    output logic         sync_o
);

    localparam logic [W-1:0] LAST   = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT    = W'(ACTIVE);
    localparam logic [W-1:0] S_BEG  = W'(SYNC_START);
    localparam logic [W-1:0] S_END  = W'(SYNC_END);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap_o   = inc_i && (cnt_q == LAST);
    assign active_o = cnt_q < ACT;
    assign sync_o   = (cnt_q >= S_BEG) && (cnt_q < S_END);
    assign cnt_o    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: two axis counters and a registered decode stage.
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FRONT  = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BACK   = vga_timing_pkg::H_BACK,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FRONT  = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BACK   = vga_timing_pkg::V_BACK,
    parameter bit SYNC_POL = vga_timing_pkg::SYNC_POL,
    parameter int CNT_W    = vga_timing_pkg::CNT_W
) (
    input  logic             clk_pix,
    input  logic             reset,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SB  = H_ACTIVE + H_FRONT;
    localparam int V_SB  = V_ACTIVE + V_FRONT;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_act;
    logic             v_act;
    logic             h_sync;
    logic             v_sync;

    axis_timing_counter #(
        .W          (CNT_W),
        .TOTAL      (H_TOT),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_SB),
        .SYNC_END   (H_SB + H_SYNC)
    ) u_h (
        .clk_i    (clk_pix),
        .rst_i    (reset),
        .inc_i    (en),
        .cnt_o    (h_cnt),
        .wrap_o   (h_wrap),
        .active_o (h_act),
        .sync_o   (h_sync)
    );

    axis_timing_counter #(
        .W          (CNT_W),
        .TOTAL      (V_TOT),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_SB),
        .SYNC_END   (V_SB + V_SYNC)
    ) u_v (
        .clk_i    (clk_pix),
        .rst_i    (reset),
        .inc_i    (h_wrap),
        .cnt_o    (v_cnt),
        .wrap_o   (v_wrap),
        .active_o (v_act),
        .sync_o   (v_sync)
    );

    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             ls_q, ls_d;
    logic             fs_q, fs_d;
    logic             vis;

    assign vis = h_act && v_act;

    // Outputs decode the counter value before this edge's increment.
    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        x_d     = x_q;
        y_d     = y_q;
        ls_d    = ls_q;
        fs_d    = fs_q;
        if (en) begin
            hsync_d = vga_timing_pkg::sync_level(h_sync, SYNC_POL);
            vsync_d = vga_timing_pkg::sync_level(v_sync, SYNC_POL);
            de_d    = vis;
            x_d     = vis ? h_cnt : '0;
            y_d     = vis ? v_cnt : '0;
            ls_d    = (h_cnt == '0);
            fs_d    = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    always_ff @(posedge clk_pix) begin
        if (reset) begin
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

    logic unused_ok;
    assign unused_ok = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default 640x480 instance for line-level checks, small-raster
// SYNC_POL=1 instance for frame wrap, random enable and reset checks.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
    } out_t;

    typedef struct {
        int   cyc;
        logic de;
        int   x;
        int   y;
        logic hs;
        logic ls;
        logic fs;
    } vec_t;

    localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVA = 4, SVF = 1, SVS = 2, SVB = 2;
    localparam int SHT = SHA + SHF + SHS + SHB;
    localparam int SVT = SVA + SVF + SVS + SVB;
    localparam int SFR = SHT * SVT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en_a = 1'b0;
    logic en_b = 1'b0;

    logic       hs_a, vs_a, de_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       hs_b, vs_b, de_b, ls_b, fs_b;
    logic [3:0] x_b, y_b;

    int n_chk = 0;
    int n_fail = 0;

    always #20 clk = ~clk;

    vga_timing_gen dut (
        .clk_pix     (clk),
        .reset       (reset),
        .en          (en_a),
        .hsync       (hs_a),
        .vsync       (vs_a),
        .de          (de_a),
        .x           (x_a),
        .y           (y_a),
        .line_start  (ls_a),
        .frame_start (fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE (SHA), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
        .V_ACTIVE (SVA), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB),
        .SYNC_POL (1'b1), .CNT_W (4)
    ) dut_s (
        .clk_pix     (clk),
        .reset       (reset),
        .en          (en_b),
        .hsync       (hs_b),
        .vsync       (vs_b),
        .de          (de_b),
        .x           (x_b),
        .y           (y_b),
        .line_start  (ls_b),
        .frame_start (fs_b)
    );

    // Raster position n enabled edges after reset, decoded from the rules.
    function automatic out_t model(int n, int ha, int hf, int hs, int hb,
                                   int va, int vf, int vs, int vb, bit pol);
        out_t o;
        int ht = ha + hf + hs + hb;
        int vt = va + vf + vs + vb;
        int h = n % ht;
        int v = (n / ht) % vt;
        o.de = (h < ha) && (v < va);
        o.x  = o.de ? 10'(h) : 10'd0;
        o.y  = o.de ? 10'(v) : 10'd0;
        o.hs = (h >= ha + hf && h < ha + hf + hs) ? pol : !pol;
        o.vs = (v >= va + vf && v < va + vf + vs) ? pol : !pol;
        o.ls = (h == 0);
        o.fs = (h == 0) && (v == 0);
        return o;
    endfunction

    function automatic out_t rst_val(bit pol);
        out_t o = '0;
        o.hs = !pol;
        o.vs = !pol;
        return o;
    endfunction

    function automatic out_t get_a();
        out_t o;
        o.hs = hs_a; o.vs = vs_a; o.de = de_a;
        o.x = x_a; o.y = y_a; o.ls = ls_a; o.fs = fs_a;
        return o;
    endfunction

    function automatic out_t get_b();
        out_t o;
        o.hs = hs_b; o.vs = vs_b; o.de = de_b;
        o.x = 10'(x_b); o.y = 10'(y_b); o.ls = ls_b; o.fs = fs_b;
        return o;
    endfunction

    task automatic chk(string nm, int cyc, out_t a, out_t e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @%0d: got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b, want hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
                     nm, cyc, a.hs, a.vs, a.de, a.x, a.y, a.ls, a.fs,
                     e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs);
        end
    endtask

    task automatic chk_int(string nm, int a, int e);
        n_chk++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic out_t mdl_a(int n);
        return model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    endfunction

    function automatic out_t mdl_b(int n);
        return model(n, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1);
    endfunction

    vec_t tbl[11];

    initial begin
        out_t exp_b;
        out_t act;
        int   ti;
        int   n;
        int   c_de, c_vs, c_fs, c_ls;

        tbl[0]  = '{0,   1'b1, 0,   0, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{1,   1'b1, 1,   0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{639, 1'b1, 639, 0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{640, 1'b0, 0,   0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{655, 1'b0, 0,   0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{656, 1'b0, 0,   0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{751, 1'b0, 0,   0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{752, 1'b0, 0,   0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{799, 1'b0, 0,   0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{800, 1'b1, 0,   1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{801, 1'b1, 1,   1, 1'b1, 1'b0, 1'b0};

        reset = 1'b1;
        en_a  = 1'b1;
        en_b  = 1'b1;
        tick();
        tick();
        chk("reset_a", 0, get_a(), rst_val(1'b0));
        chk("reset_b", 0, get_b(), rst_val(1'b1));

        // One line and a bit on the full-size raster.
        reset = 1'b0;
        en_b  = 1'b0;
        ti = 0;
        for (int k = 0; k < 1200; k++) begin
            tick();
            act = get_a();
            chk("line_a", k, act, mdl_a(k));
            if (ti < 11 && tbl[ti].cyc == k) begin
                n_chk++;
                if (act.de !== tbl[ti].de || act.x != 10'(tbl[ti].x) ||
                    act.y != 10'(tbl[ti].y) || act.hs !== tbl[ti].hs ||
                    act.ls !== tbl[ti].ls || act.fs !== tbl[ti].fs) begin
                    n_fail++;
                    $display("FAIL vec[%0d] @%0d: got de=%b x=%0d y=%0d hs=%b ls=%b fs=%b, want de=%b x=%0d y=%0d hs=%b ls=%b fs=%b",
                             ti, k, act.de, act.x, act.y, act.hs, act.ls,
                             act.fs, tbl[ti].de, tbl[ti].x, tbl[ti].y,
                             tbl[ti].hs, tbl[ti].ls, tbl[ti].fs);
                end
                ti++;
            end
        end
        chk_int("small_idle_hold", int'(get_b()), int'(rst_val(1'b1)));

        // Mid-line reset with en low: reset must still win.
        reset = 1'b1;
        en_a  = 1'b0;
        tick();
        chk("midreset_a", 1200, get_a(), rst_val(1'b0));
        reset = 1'b0;
        en_a  = 1'b1;
        tick();
        chk("restart_a0", 0, get_a(), mdl_a(0));
        tick();
        chk("restart_a1", 1, get_a(), mdl_a(1));
        en_a = 1'b0;

        // Small raster: clean frame, then random enable with a reset pulse.
        reset = 1'b1;
        tick();
        chk("reset_b2", 0, get_b(), rst_val(1'b1));
        reset = 1'b0;
        n = 0;
        exp_b = rst_val(1'b1);
        c_de = 0; c_vs = 0; c_fs = 0; c_ls = 0;
        for (int c = 0; c < 8 * SFR; c++) begin
            en_b  = (c < SFR + 1) ? 1'b1 : 1'($urandom_range(0, 1));
            reset = (c == 5 * SFR + 37);
            tick();
            if (reset) begin
                exp_b = rst_val(1'b1);
                n = 0;
            end else if (en_b) begin
                exp_b = mdl_b(n);
                n++;
            end
            act = get_b();
            chk("stream_b", c, act, exp_b);
            if (c < SFR) begin
                c_de += int'(act.de);
                c_vs += int'(act.vs);
                c_fs += int'(act.fs);
                c_ls += int'(act.ls);
            end
            if (c == SFR) chk_int("wrap_b_fs", int'(act.fs), 1);
            n_chk++;
            if (act.x >= 10'(SHA) || act.y >= 10'(SVA) ||
                (!act.de && (act.x != 0 || act.y != 0))) begin
                n_fail++;
                $display("FAIL bounds_b @%0d: de=%b x=%0d y=%0d", c,
                         act.de, act.x, act.y);
            end
        end
        reset = 1'b0;
        en_b  = 1'b0;
        chk_int("frame_de_cnt", c_de, SHA * SVA);
        chk_int("frame_vs_cnt", c_vs, SVS * SHT);
        chk_int("frame_fs_cnt", c_fs, 1);
        chk_int("frame_ls_cnt", c_ls, SVT);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
